// File: rtl/ifetch_linebuf_if.sv
// Cache read channel between the fetch stage and the instruction cache.
// Signals: c_valid, c_addr (line-aligned) from fetch; c_ready, c_rdata (one line) from cache.
interface ifetch_linebuf_if #(
  parameter int unsigned LINE_WORDS = 4
);
  logic                      c_valid;
  logic [31:0]               c_addr;
  logic                      c_ready;
  logic [32*LINE_WORDS-1:0]  c_rdata;

  modport master (
    output c_valid, c_addr,
    input  c_ready, c_rdata
  );

  modport slave (
    input  c_valid, c_addr,
    output c_ready, c_rdata
  );
endinterface

// File: rtl/ifetch_linebuf.sv
// Fetch stage with an optional direct-mapped line buffer in front of a line-wide cache read channel.
// Ports: clk, rst (sync, active-high); addr, pipe_stall, pipe_flush, inv in;
//   inst (registered), error (comb fault), stall_req, flush_req (always 0) out;
//   cache: ifetch_linebuf_if.master (c_valid, c_addr, c_ready, c_rdata).
// Build option: define IFETCH_LINEBUF_EN to include the line buffer;
//   without it every legal fetch goes to the cache and inv is ignored.
module ifetch_linebuf #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LB_ENTRIES = 4,
  parameter logic [31:0] MEM_BASE   = 32'h80000000,
  parameter logic [31:0] MEM_SIZE   = 32'h00040000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             pipe_stall,
  input  logic             pipe_flush,
  input  logic             inv,
  output logic [31:0]      inst,
  output logic             error,
  output logic             stall_req,
  output logic [3:0]       flush_req,
  ifetch_linebuf_if.master cache
);

  localparam int OFF = $clog2(4 * LINE_WORDS);
  localparam int WB  = (LINE_WORDS > 1) ?
                       $clog2(LINE_WORDS) : 1;
  localparam int LW  = 32 * LINE_WORDS;

  typedef enum logic {RUN, FILL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   caddr_q, caddr_d;
  logic [31:0]   line_addr;
  logic [WB-1:0] wsel;
  logic [32:0]   a33, lo, hi;
  logic          hit;
  logic [LW-1:0] hit_line;
  logic          fill_done;
  logic [31:0]   load_val;
  logic [31:0]   fill_word, hit_word;

  assign flush_req = 4'b0000;

  assign line_addr =
    addr & ~(32'(4 * LINE_WORDS) - 32'd1);

  assign wsel = (LINE_WORDS > 1) ?
                WB'(addr >> 2) : '0;

  // 33-bit window compare so MEM_BASE+MEM_SIZE
  // never wraps.
  assign a33   = {1'b0, addr};
  assign lo    = {1'b0, MEM_BASE};
  assign hi    = {1'b0, MEM_BASE} +
                 {1'b0, MEM_SIZE};
  assign error = (addr[1:0] != 2'b00) ||
                 (a33 < lo) || (a33 >= hi);

`ifdef IFETCH_LINEBUF_EN
  localparam int IBR = $clog2(LB_ENTRIES);
  localparam int IB  = (IBR > 0) ? IBR : 1;
  localparam int TW  = 32 - OFF - IBR;

  logic [LB_ENTRIES-1:0] vld_q;
  logic [TW-1:0]         tag_q [LB_ENTRIES];
  logic [LW-1:0]         dat_q [LB_ENTRIES];
  logic [31:0]           rline, wline;
  logic [IB-1:0]         ridx, widx;
  logic [TW-1:0]         rtag, wtag;

  assign rline = addr >> OFF;
  assign ridx  = IB'(rline &
                 32'(LB_ENTRIES - 1));
  assign rtag  = TW'(rline >> IBR);

  // Fill target comes from the line actually
  // requested on the channel.
  assign wline = cache.c_addr >> OFF;
  assign widx  = IB'(wline &
                 32'(LB_ENTRIES - 1));
  assign wtag  = TW'(wline >> IBR);

  // Registered contents only: an inv in this
  // cycle does not affect this cycle's hit.
  assign hit      = vld_q[ridx] &&
                    (tag_q[ridx] == rtag);
  assign hit_line = dat_q[ridx];

  // inv wins over a same-cycle fill, leaving
  // the freshly written entry invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (inv) begin
      vld_q <= '0;
    end else if (fill_done) begin
      vld_q[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[widx] <= wtag;
      dat_q[widx] <= cache.c_rdata;
    end
  end
`else
  localparam int unsigned unused_entries =
    LB_ENTRIES;
  logic unused_inv;

  assign unused_inv = inv;
  assign hit        = 1'b0;
  assign hit_line   = '0;
`endif

  always_comb begin
    fill_word = '0;
    hit_word  = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (WB'(i) == wsel) begin
        fill_word = cache.c_rdata[i*32 +: 32];
        hit_word  = hit_line[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    caddr_d       = caddr_q;
    cache.c_valid = 1'b0;
    cache.c_addr  = caddr_q;
    stall_req     = 1'b0;
    fill_done     = 1'b0;
    load_val      = '0;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          error: begin
            load_val = '0;
          end
          (!error && hit): begin
            load_val = hit_word;
          end
          (!error && !hit): begin
            cache.c_valid = 1'b1;
            cache.c_addr  = line_addr;
            caddr_d       = line_addr;
            if (cache.c_ready) begin
              fill_done = 1'b1;
              load_val  = fill_word;
            end else begin
              stall_req = 1'b1;
              state_d   = FILL;
            end
          end
          default: begin
            load_val = '0;
          end
        endcase
      end
      FILL: begin
        cache.c_valid = 1'b1;
        if (cache.c_ready) begin
          fill_done = 1'b1;
          load_val  = fill_word;
          state_d   = RUN;
        end else begin
          stall_req = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
    end
  end

  // A stalled fetch keeps the old word; the
  // completing fill drops stall_req and loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst <= '0;
    end else if (pipe_flush) begin
      inst <= '0;
    end else if (pipe_stall) begin
      inst <= inst;
    end else if (!stall_req) begin
      inst <= load_val;
    end
  end

endmodule

// File: tb/tb_ifetch_linebuf.sv
// Testbench for ifetch_linebuf: directed scenarios plus random fetches
// checked against a line-level model of the buffer and memory.
module tb_ifetch_linebuf;
  localparam int LW = 4;
  localparam int NE = 4;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam logic [31:0] SIZE = 32'h00040000;
`ifdef IFETCH_LINEBUF_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        pipe_stall, pipe_flush, inv;
  logic [31:0] inst;
  logic        error, stall_req;
  logic [3:0]  flush_req;

  ifetch_linebuf_if #(.LINE_WORDS(LW)) cif();

  ifetch_linebuf #(
    .LINE_WORDS(LW),
    .LB_ENTRIES(NE),
    .MEM_BASE(BASE),
    .MEM_SIZE(SIZE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .pipe_stall(pipe_stall),
    .pipe_flush(pipe_flush),
    .inv(inv),
    .inst(inst),
    .error(error),
    .stall_req(stall_req),
    .flush_req(flush_req),
    .cache(cif)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          use_abcd = 1'b0;
  bit          mv [NE];
  logic [31:0] ml [NE];
  logic [31:0] md [NE][LW];
  logic [31:0] exp_inst;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    if (use_abcd)
      return 32'hA + ((a >> 2) % LW);
    return a ^ 32'h1234_5678;
  endfunction

  function automatic logic [32*LW-1:0] line_data(
    input logic [31:0] la);
    logic [32*LW-1:0] d;
    d = '0;
    for (int w = 0; w < LW; w++)
      d[32*w +: 32] = mem_word(la + 32'(4*w));
    return d;
  endfunction

  function automatic bit bad(input logic [31:0] a);
    longint unsigned x;
    x = a;
    return (x % 4 != 0) || (x < BASE) ||
           (x >= longint'(BASE) + longint'(SIZE));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NE; i++) mv[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    addr        = 32'h0;
    pipe_stall  = 1'b0;
    pipe_flush  = 1'b0;
    inv         = 1'b0;
    cif.c_ready = 1'b0;
    cif.c_rdata = '0;
  endtask

  // One fetch: present a, let the cache answer
  // lat cycles after the request, check all
  // channel/stall behaviour and the loaded inst.
  task automatic fetch(input logic [31:0] a,
                       input int lat,
                       input bit di,
                       input bit fl,
                       input bit ps);
    logic [31:0] la, want;
    bit e, h, m, done;
    int stalls, ix;
    la = a & ~32'(4*LW - 1);
    ix = int'((a / (4*LW)) % NE);
    e  = bad(a);
    h  = !e && EN && mv[ix] && (ml[ix] == la);
    m  = !e && !h;
    @(negedge clk);
    idle_inputs();
    addr       = a;
    pipe_flush = fl;
    pipe_stall = ps;
    stalls = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (cyc == 0) begin
        n_tests++;
        if (error !== e) begin
          n_fail++;
          $display("FAIL error @%h: got %b want %b",
                   a, error, e);
        end
        n_tests++;
        if (cif.c_valid !== m) begin
          n_fail++;
          $display("FAIL c_valid @%h: got %b want %b",
                   a, cif.c_valid, m);
        end
      end
      if (cif.c_valid === 1'b1) begin
        n_tests++;
        if (cif.c_addr !== la) begin
          n_fail++;
          $display("FAIL c_addr @%h: got %h want %h",
                   a, cif.c_addr, la);
        end
        if (cyc >= lat) begin
          cif.c_ready = 1'b1;
          cif.c_rdata = line_data(cif.c_addr);
        end
      end
      #1;
      if (stall_req === 1'b0) begin
        inv  = di;
        done = 1'b1;
      end else begin
        stalls++;
        @(negedge clk);
        cif.c_ready = 1'b0;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout @%h: stall_req %b want 0",
               a, stall_req);
    end
    n_tests++;
    if (stalls != (m ? lat : 0)) begin
      n_fail++;
      $display("FAIL stall_cycles @%h: got %0d want %0d",
               a, stalls, m ? lat : 0);
    end
    if (e)      want = 32'h0;
    else if (h) want = md[ix][(a >> 2) % LW];
    else        want = mem_word(a);
    if (m) begin
      for (int w = 0; w < LW; w++)
        md[ix][w] = mem_word(la + 32'(4*w));
      ml[ix] = la;
      mv[ix] = 1'b1;
    end
    if (di) model_clear();
    if (fl)       exp_inst = 32'h0;
    else if (!ps) exp_inst = want;
    @(posedge clk);
    #1;
    n_tests++;
    if (inst !== exp_inst) begin
      n_fail++;
      $display("FAIL inst @%h: got %h want %h",
               a, inst, exp_inst);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_inst = 32'h0;
    #1;
    n_tests++;
    if (inst !== 32'h0 || cif.c_valid !== 1'b0 ||
        stall_req !== 1'b0 || flush_req !== 4'h0 ||
        error !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: got inst=%h cv=%b st=%b fr=%h er=%b want 0 0 0 0 1",
               inst, cif.c_valid, stall_req,
               flush_req, error);
    end
  endtask

  task automatic test_cold_miss();
    use_abcd = 1'b1;
    fetch(32'h80000004, 3, 0, 0, 0);
    n_tests++;
    if (inst !== 32'hB) begin
      n_fail++;
      $display("FAIL cold_miss: got %h want %h",
               inst, 32'hB);
    end
  endtask

  task automatic test_hit();
    fetch(32'h80000008, 0, 0, 0, 0);
    n_tests++;
    if (inst !== 32'hC) begin
      n_fail++;
      $display("FAIL hit: got %h want %h",
               inst, 32'hC);
    end
    use_abcd = 1'b0;
  endtask

  task automatic test_faults();
    logic [31:0] fa [3];
    fa[0] = 32'h80000002;
    fa[1] = 32'h7FFFFFFC;
    fa[2] = 32'h80040000;
    for (int i = 0; i < 3; i++) begin
      fetch(fa[i], 1, 0, 0, 0);
      n_tests++;
      if (inst !== 32'h0) begin
        n_fail++;
        $display("FAIL fault_inst @%h: got %h want 0",
                 fa[i], inst);
      end
    end
    fetch(32'h8003FFFC, 1, 0, 0, 0);
  endtask

  task automatic test_conflict();
    fetch(32'h80000000, 1, 0, 0, 0);
    fetch(32'h80000040, 2, 0, 0, 0);
    fetch(32'h80000000, 1, 0, 0, 0);
    fetch(32'h8000004C, 0, 0, 0, 0);
  endtask

  task automatic test_inv();
    fetch(32'h80000000, 0, 0, 0, 0);
    fetch(32'h80000004, 0, 1, 0, 0);
    fetch(32'h80000000, 2, 0, 0, 0);
    fetch(32'h80000010, 2, 1, 0, 0);
    fetch(32'h80000014, 1, 0, 0, 0);
  endtask

  task automatic test_flush_fill();
    fetch(32'h80000020, 3, 0, 1, 0);
    fetch(32'h80000024, 0, 0, 0, 0);
    fetch(32'h80000028, 1, 0, 0, 1);
  endtask

  task automatic test_reset_mid_fill();
    fetch(32'h80000000, 1, 0, 0, 0);
    @(negedge clk);
    idle_inputs();
    addr = 32'h80000100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    addr = 32'h0;
    model_clear();
    exp_inst = 32'h0;
    #1;
    n_tests++;
    if (inst !== 32'h0 || stall_req !== 1'b0 ||
        cif.c_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fill: got inst=%h st=%b cv=%b want 0 0 0",
               inst, stall_req, cif.c_valid);
    end
    fetch(32'h80000000, 2, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 11);
      if (r == 0)
        a = BASE + ($urandom_range(0, 255) << 2) +
            $urandom_range(1, 3);
      else if (r == 1)
        a = BASE - 4 * $urandom_range(1, 8);
      else if (r == 2)
        a = BASE + SIZE + 4 * $urandom_range(0, 8);
      else if (r == 3)
        a = BASE + SIZE - 4 * $urandom_range(1, 8);
      else
        a = BASE + 16 * $urandom_range(0, 11) +
            4 * $urandom_range(0, 3);
      fetch(a, int'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    exp_inst = 32'h0;
    model_clear();
    test_reset();
    test_cold_miss();
    test_hit();
    test_faults();
    test_conflict();
    test_inv();
    test_flush_fill();
    test_reset_mid_fill();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_linebuf.md
IFETCH_LINEBUF -- requirements
Module: ifetch_linebuf

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per cache line (power of 2, 1..16).
REQ-002 SHALL have parameter LB_ENTRIES, default 4, meaning direct-mapped line-buffer entries (power of 2, 1..16).
REQ-003 SHALL have parameter MEM_BASE, default 32'h80000000, meaning first legal fetch address.
REQ-004 SHALL have parameter MEM_SIZE, default 32'h00040000, meaning legal fetch window size in bytes (power of 2).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port addr, input, 32, meaning fetch PC, held stable by the pipeline while stall_req=1.
REQ-008 SHALL have port pipe_stall, input, 1, meaning global pipeline stall.
REQ-009 SHALL have port pipe_flush, input, 1, meaning global pipeline flush.
REQ-010 SHALL have port inv, input, 1, meaning invalidate all line-buffer entries (fence.i).
REQ-011 SHALL have port inst, output, 32, meaning registered fetched instruction.
REQ-012 SHALL have port error, output, 1, meaning combinational fetch-address fault.
REQ-013 SHALL have port stall_req, output, 1, meaning fetch stage requests stall.
REQ-014 SHALL have port flush_req, output, 4, meaning flush request, tied to 4'b0000.
REQ-015 SHALL have ports c_valid output 1, c_addr output 32 (line-aligned), c_ready input 1, c_rdata input 32*LINE_WORDS, meaning cache read channel; c_rdata valid only in cycles with c_valid=1 and c_ready=1.

Function
REQ-016 SHALL assert error when addr[1:0]!=0, addr<MEM_BASE, or addr>=MEM_BASE+MEM_SIZE (33-bit compare, no wrap).
REQ-017 SHALL, when error=1, issue no cache request, keep stall_req=0, and capture inst=32'h00000000 at next unstalled edge.
REQ-018 SHALL index the line buffer by line-number LSBs and store tag and valid bit per entry; hit = valid and tag match.
REQ-019 SHALL implement FSM states RUN and FILL; reset state RUN.
REQ-020 SHALL, in RUN on hit, keep stall_req=0, c_valid=0, and load the selected word into inst at the edge (zero-latency fetch, result next cycle).
REQ-021 SHALL, in RUN on non-error miss, drive stall_req=1, c_valid=1, c_addr=addr with low log2(4*LINE_WORDS) bits cleared, latch c_addr, and go to FILL unless c_ready=1 that cycle.
REQ-022 SHALL, in FILL, hold c_valid=1 with latched c_addr and stall_req=1 until c_ready=1.
REQ-023 SHALL, on c_ready=1 with c_valid=1, write c_rdata into the entry, drive stall_req=0 that cycle, load word addr[log2(4*LINE_WORDS)-1:2] of c_rdata into inst, and go to RUN.
REQ-024 SHALL update inst priority: rst, then pipe_flush (inst=0), then pipe_stall (hold), then load.
REQ-025 SHALL, on pipe_flush during FILL, complete the outstanding fill (line written, FSM to RUN) but load inst=0.
REQ-026 SHALL, on inv, clear all valid bits at the edge; inv coinciding with fill completion leaves that entry invalid, while inst still receives the forwarded word.
REQ-027 SHALL evaluate a same-cycle hit against pre-inv contents (inv takes effect next cycle).

Reset
REQ-028 SHALL, on rst, set inst=0, FSM=RUN, all valid bits=0, latched c_addr=0; c_valid=0 and stall_req=0 in the following cycle unless a miss is present.
REQ-029 SHALL abandon a FILL on rst mid-fill; c_ready arriving after reset SHALL be ignored.

Configuration
REQ-030 SHALL, with IFETCH_LINEBUF_EN defined, include the line buffer as REQ-018..027.
REQ-031 SHALL, without IFETCH_LINEBUF_EN, contain no line-buffer storage, treat every non-error fetch as a miss (minimum one stall cycle unless c_ready is already 1), and ignore inv.

Verification
REQ-032 SHALL cover cold miss: addr=0x80000004, c_ready after 3 cycles with line {D,C,B,A} -> stall_req high 3 cycles, c_addr=0x80000000, inst=0xB.
REQ-033 SHALL cover hit: following fetch 0x80000008 -> stall_req=0, c_valid=0, inst=0xC next cycle.
REQ-034 SHALL cover faults: addr=0x80000002, 0x7FFFFFFC, 0x80040000 -> error=1, c_valid=0, inst=0.
REQ-035 SHALL cover conflict: fetch 0x80000000 then 0x80000040 (LB_ENTRIES=4) -> second misses, then 0x80000000 misses again.
REQ-036 SHALL cover inv: inv pulse after fill of 0x80000000 -> refetch of 0x80000000 misses; inv on fill-complete cycle -> next fetch to same line misses.
REQ-037 SHALL cover flush mid-FILL: pipe_flush during FILL -> inst=0, fill completes, subsequent fetch of same line hits.
